// File: rtl/pt_reg_fifo.sv
// pt_reg_fifo
//   Parametrised register-based hop buffer for the PtRing router. Any depth
//   of 2 or more (power of two not required), first-word-fall-through head,
//   occupancy count, programmable almost-full, and push+pop on the same
//   cycle while full.
//
// Parameters
//   WIDTH    data width in bits
//   DEPTH    number of entries (>=2)
//   AFUL_TH  occupancy at or above which oAFul asserts (1..DEPTH)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears pointers and count)
//   iWrEn    write request, iWrDat write data
//   iRdEn    pop request
//   oFul     DEPTH entries held
//   oAFul    occupancy >= AFUL_TH
//   oEmpty   no entries held
//   oDatVld  thermometer of occupied slots, bit k = (count > k)
//   oCnt     current occupancy
//   oRdDat   head entry, 0 when empty
//
// Optional build macro PT_FIFO_ERR_CHK_EN
//   Adds sticky oOvf (write dropped on full) and oUdf (pop on empty)
//   outputs plus simulation assertions on count/flag consistency.
module pt_reg_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int AFUL_TH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iWrEn,
    input  logic [WIDTH-1:0]             iWrDat,
    input  logic                         iRdEn,
    output logic                         oFul,
    output logic                         oAFul,
    output logic                         oEmpty,
    output logic [DEPTH-1:0]             oDatVld,
    output logic [$clog2(DEPTH+1)-1:0]   oCnt,
    output logic [WIDTH-1:0]             oRdDat
`ifdef PT_FIFO_ERR_CHK_EN
    ,
    output logic                         oOvf,
    output logic                         oUdf
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             wr_fire;
    logic             rd_fire;

    // A pop on full frees the slot the write lands in, so iRdEn (not
    // rd_fire) is enough to let a write through while full.
    assign rd_fire = iRdEn & ~oEmpty;
    assign wr_fire = iWrEn & (~oFul | iRdEn);

    // Explicit wrap compare: DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; requests during reset are ignored.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) mem[wr_ptr] <= iWrDat;
    end

    // All status is decoded from the registered count only.
    assign oCnt   = cnt;
    assign oEmpty = (cnt == '0);
    assign oFul   = (cnt == CW'(DEPTH));
    assign oAFul  = (cnt >= CW'(AFUL_TH));
    assign oRdDat = oEmpty ? '0 : mem[rd_ptr];

    for (genvar k = 0; k < DEPTH; k++) begin : g_vld
        assign oDatVld[k] = (cnt > CW'(k));
    end

`ifdef PT_FIFO_ERR_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oOvf <= 1'b0;
            oUdf <= 1'b0;
        end else begin
            if (iWrEn & oFul & ~iRdEn) oOvf <= 1'b1;
            if (iRdEn & oEmpty)        oUdf <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_cnt_max : assert property (@(posedge clk) disable iff (rst)
        cnt <= CW'(DEPTH));
    a_flags : assert property (@(posedge clk) disable iff (rst)
        (oEmpty == (cnt == '0)) && (oFul == (cnt == CW'(DEPTH))) &&
        !(oEmpty && oFul));
`endif
`else
    // Without the checker, illegal requests are silently ignored by the
    // fire qualifiers above and no extra state exists.
`endif

endmodule

// File: tb/tb_pt_reg_fifo.sv
module tb_pt_reg_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DEPTH=4, AFUL_TH=3
    logic       rst4 = 1'b1, wr4 = 1'b0, rd4 = 1'b0;
    logic [7:0] wd4 = '0;
    logic       ful4, aful4, emp4;
    logic [3:0] vld4;
    logic [2:0] cnt4;
    logic [7:0] rdd4;
    // DUT B: DEPTH=3, default AFUL_TH=2
    logic       rst3 = 1'b1, wr3 = 1'b0, rd3 = 1'b0;
    logic [7:0] wd3 = '0;
    logic       ful3, aful3, emp3;
    logic [2:0] vld3;
    logic [1:0] cnt3;
    logic [7:0] rdd3;
`ifdef PT_FIFO_ERR_CHK_EN
    logic ovf4, udf4, ovf3, udf3;
    bit   m_ovf4, m_udf4, m_ovf3, m_udf3;
`endif

    pt_reg_fifo #(.WIDTH(8), .DEPTH(4), .AFUL_TH(3)) u_dut4 (
        .clk(clk), .rst(rst4), .iWrEn(wr4), .iWrDat(wd4), .iRdEn(rd4),
        .oFul(ful4), .oAFul(aful4), .oEmpty(emp4), .oDatVld(vld4),
        .oCnt(cnt4), .oRdDat(rdd4)
`ifdef PT_FIFO_ERR_CHK_EN
        , .oOvf(ovf4), .oUdf(udf4)
`endif
    );

    pt_reg_fifo #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .iWrEn(wr3), .iWrDat(wd3), .iRdEn(rd3),
        .oFul(ful3), .oAFul(aful3), .oEmpty(emp3), .oDatVld(vld3),
        .oCnt(cnt3), .oRdDat(rdd3)
`ifdef PT_FIFO_ERR_CHK_EN
        , .oOvf(ovf3), .oUdf(udf3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue per FIFO, updated from the request rules.
    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit live4 = 0, live3 = 0;

    always @(posedge clk) begin
        if (rst4) begin
            q4.delete();
            live4 = 1;
`ifdef PT_FIFO_ERR_CHK_EN
            m_ovf4 = 0; m_udf4 = 0;
`endif
        end else begin
            bit r, w;
`ifdef PT_FIFO_ERR_CHK_EN
            if (wr4 && q4.size() == 4 && !rd4) m_ovf4 = 1;
            if (rd4 && q4.size() == 0) m_udf4 = 1;
`endif
            r = rd4 && q4.size() > 0;
            w = wr4 && (q4.size() < 4 || rd4);
            if (r) void'(q4.pop_front());
            if (w) q4.push_back(wd4);
        end
    end

    always @(posedge clk) begin
        if (rst3) begin
            q3.delete();
            live3 = 1;
`ifdef PT_FIFO_ERR_CHK_EN
            m_ovf3 = 0; m_udf3 = 0;
`endif
        end else begin
            bit r, w;
`ifdef PT_FIFO_ERR_CHK_EN
            if (wr3 && q3.size() == 3 && !rd3) m_ovf3 = 1;
            if (rd3 && q3.size() == 0) m_udf3 = 1;
`endif
            r = rd3 && q3.size() > 0;
            w = wr3 && (q3.size() < 3 || rd3);
            if (r) void'(q3.pop_front());
            if (w) q3.push_back(wd3);
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (live4) begin
            int n;
            logic [3:0] th;
            n = q4.size();
            for (int k = 0; k < 4; k++) th[k] = (n > k);
            chk("d4_cnt", 32'(cnt4), 32'(n));
            chk("d4_empty", 32'(emp4), 32'(n == 0));
            chk("d4_ful", 32'(ful4), 32'(n == 4));
            chk("d4_aful", 32'(aful4), 32'(n >= 3));
            chk("d4_datvld", 32'(vld4), 32'(th));
            chk("d4_rddat", 32'(rdd4), (n > 0) ? 32'(q4[0]) : 32'd0);
`ifdef PT_FIFO_ERR_CHK_EN
            chk("d4_ovf", 32'(ovf4), 32'(m_ovf4));
            chk("d4_udf", 32'(udf4), 32'(m_udf4));
`endif
        end
        if (live3) begin
            int n;
            logic [2:0] th;
            n = q3.size();
            for (int k = 0; k < 3; k++) th[k] = (n > k);
            chk("d3_cnt", 32'(cnt3), 32'(n));
            chk("d3_cnt_range", 32'(cnt3 <= 2'd3), 32'd1);
            chk("d3_empty", 32'(emp3), 32'(n == 0));
            chk("d3_ful", 32'(ful3), 32'(n == 3));
            chk("d3_aful", 32'(aful3), 32'(n >= 2));
            chk("d3_datvld", 32'(vld3), 32'(th));
            chk("d3_rddat", 32'(rdd3), (n > 0) ? 32'(q3[0]) : 32'd0);
`ifdef PT_FIFO_ERR_CHK_EN
            chk("d3_ovf", 32'(ovf3), 32'(m_ovf3));
            chk("d3_udf", 32'(udf3), 32'(m_udf3));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic w, input logic [7:0] d, input logic r);
        wr4 = w; wd4 = d; rd4 = r;
        tick();
        wr4 = 0; rd4 = 0;
    endtask

    initial begin
        int sent;
        // 1. reset held with a write pending
        rst4 = 1; rst3 = 1; wr4 = 1; wd4 = 8'h77;
        repeat (3) tick();
        rst4 = 0; rst3 = 0; wr4 = 0;
        chk("t1_empty", 32'(emp4), 32'd1);
        chk("t1_ful", 32'(ful4), 32'd0);
        chk("t1_cnt", 32'(cnt4), 32'd0);
        chk("t1_vld", 32'(vld4), 32'h0);
        chk("t1_rddat", 32'(rdd4), 32'h0);

        // 2. fill / drain
        for (int i = 1; i <= 4; i++) begin
            op4(1, 8'(i), 0);
            chk("t2_cnt", 32'(cnt4), 32'(i));
            chk("t2_aful", 32'(aful4), 32'(i >= 3));
        end
        chk("t2_ful", 32'(ful4), 32'd1);
        chk("t2_vld", 32'(vld4), 32'hf);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_pop", 32'(rdd4), 32'(i));
            op4(0, 0, 1);
        end
        chk("t2_empty", 32'(emp4), 32'd1);

        // 3. overflow then under-read
        for (int i = 0; i < 4; i++) op4(1, 8'hA0 + 8'(i), 0);
        op4(1, 8'hAA, 0);
        chk("t3_cnt", 32'(cnt4), 32'd4);
        chk("t3_head", 32'(rdd4), 32'hA0);
`ifdef PT_FIFO_ERR_CHK_EN
        chk("t3_ovf", 32'(ovf4), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("t3_pop", 32'(rdd4), 32'hA0 + 32'(i));
            op4(0, 0, 1);
        end
        op4(0, 0, 1);
        chk("t3_udf_empty", 32'(emp4), 32'd1);
        chk("t3_udf_cnt", 32'(cnt4), 32'd0);
`ifdef PT_FIFO_ERR_CHK_EN
        chk("t3_udf", 32'(udf4), 32'd1);
`endif

        // 4. full with simultaneous read and write
        for (int i = 0; i < 4; i++) op4(1, 8'h10 + 8'(i), 0);
        op4(1, 8'h14, 1);
        chk("t4_cnt", 32'(cnt4), 32'd4);
        chk("t4_head", 32'(rdd4), 32'h11);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_pop", 32'(rdd4), 32'h10 + 32'(i));
            op4(0, 0, 1);
        end
        chk("t4_empty", 32'(emp4), 32'd1);

        // 6. reset mid-operation
        op4(1, 8'h31, 0);
        op4(1, 8'h32, 0);
        chk("t6_cnt2", 32'(cnt4), 32'd2);
        rst4 = 1; wr4 = 1; wd4 = 8'h99; rd4 = 1;
        tick();
        rst4 = 0; wr4 = 0; rd4 = 0;
        chk("t6_empty", 32'(emp4), 32'd1);
        chk("t6_cnt0", 32'(cnt4), 32'd0);
        op4(1, 8'h55, 0);
        chk("t6_rddat", 32'(rdd4), 32'h55);

        // 5. random stream through DEPTH=3 (wraps repeatedly)
        sent = 0;
        for (int c = 0; c < 400 && sent < 20; c++) begin
            wr3 = 1'($urandom_range(0, 1));
            rd3 = 1'($urandom_range(0, 1));
            wd3 = 8'h80 + 8'(sent);
            if (wr3) sent++;
            tick();
        end
        wr3 = 0;
        if (sent < 20) chk("t5_stream_budget", 32'(sent), 32'd20);
        rd3 = 1;
        for (int c = 0; c < 10 && !emp3; c++) tick();
        rd3 = 0;
        chk("t5_drained", 32'(emp3), 32'd1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
